// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU decoder: control codes, ALU op
// classes, MDU op field and the sequencing FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_PASSB = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLTU  = 4'b0101,
        ALU_SUB   = 4'b0110,
        ALU_SLT   = 4'b0111,
        ALU_SLL   = 4'b1000,
        ALU_SRL   = 4'b1001,
        ALU_SRA   = 4'b1010
    } alucontrol_t;

    typedef enum logic [1:0] {
        AOP_ADD   = 2'b00,
        AOP_SUB   = 2'b01,
        AOP_FUNC  = 2'b10,
        AOP_PASSB = 2'b11
    } aluop_t;

    typedef logic [2:0] mdu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/alu_decode_comb.sv
// Pure combinational decode of the RV32I/RV32M ALU fields into a
// control code plus M-op and illegal flags.
module alu_decode_comb
    import alu_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [1:0]  aluop,
    input  logic        op5,
    input  logic        f7b5,
    input  logic        f7b0,
    input  logic [2:0]  funct3,
    output alucontrol_t alucontrol,
    output logic        is_m,
    output logic        illegal
);

    logic m_enc;
    logic r_sub;

    assign m_enc = op5 & f7b0;
    assign r_sub = op5 & f7b5;

    always_comb begin
        alucontrol = ALU_ADD;
        is_m       = 1'b0;
        illegal    = 1'b0;
        unique case (aluop_t'(aluop))
            AOP_ADD:   alucontrol = ALU_ADD;
            AOP_SUB:   alucontrol = ALU_SUB;
            AOP_PASSB: alucontrol = ALU_PASSB;
            AOP_FUNC: begin
                if (m_enc) begin
                    is_m    = ENABLE_M;
                    illegal = !ENABLE_M;
                end else if (r_sub && funct3 != 3'b000 && funct3 != 3'b101) begin
                    // funct7[5] only qualifies sub and sra on R-type
                    illegal = 1'b1;
                end else begin
                    unique case (funct3)
                        3'b000: alucontrol = r_sub ? ALU_SUB : ALU_ADD;
                        3'b001: alucontrol = ALU_SLL;
                        3'b010: alucontrol = ALU_SLT;
                        3'b011: alucontrol = ALU_SLTU;
                        3'b100: alucontrol = ALU_XOR;
                        3'b101: alucontrol = f7b5 ? ALU_SRA : ALU_SRL;
                        3'b110: alucontrol = ALU_OR;
                        3'b111: alucontrol = ALU_AND;
                    endcase
                end
            end
        endcase
    end

endmodule

// File: rtl/alu_decode_mc.sv
// Multi-cycle ALU decoder: registered ready/valid result stage with
// fixed-latency MDU sequencing, stall and flush.
module alu_decode_mc
    import alu_pkg::*;
#(
    parameter int ALUCTRL_W = 4,
    parameter bit ENABLE_M  = 1'b1,
    parameter int MUL_LAT   = 2,
    parameter int DIV_LAT   = 33
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 op5,
    input  logic                 f7b5,
    input  logic                 f7b0,
    input  logic [2:0]           funct3,
    input  logic [1:0]           aluop,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 mdu_sel,
    output logic                 illegal,
    output logic                 mdu_start,
    output logic [2:0]           mdu_op,
    output logic                 busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_LAT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ov_q, ov_d;
    alucontrol_t        code_q, code_d;
    logic               msel_q, msel_d;
    logic               ill_q, ill_d;
    logic               start_q, start_d;
    mdu_op_t            op_q, op_d;

    alucontrol_t        dec_code;
    logic               dec_is_m;
    logic               dec_ill;
    logic               accept;
    logic               fire;

    alu_decode_comb #(
        .ENABLE_M (ENABLE_M)
    ) u_dec (
        .aluop      (aluop),
        .op5        (op5),
        .f7b5       (f7b5),
        .f7b0       (f7b0),
        .funct3     (funct3),
        .alucontrol (dec_code),
        .is_m       (dec_is_m),
        .illegal    (dec_ill)
    );

    assign in_ready = (state_q == IDLE) & (!ov_q | out_ready) & !flush;
    assign accept   = in_valid & in_ready;
    assign fire     = ov_q & out_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ov_d    = ov_q;
        code_d  = code_q;
        msel_d  = msel_q;
        ill_d   = ill_q;
        start_d = 1'b0;
        op_d    = op_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            ov_d    = 1'b0;
        end else begin
            if (fire) ov_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept && dec_is_m) begin
                        state_d = BUSY;
                        cnt_d   = funct3[2] ? DIV_LAST : MUL_LAST;
                        start_d = 1'b1;
                        op_d    = funct3;
                    end else if (accept) begin
                        ov_d   = 1'b1;
                        code_d = dec_code;
                        msel_d = 1'b0;
                        ill_d  = dec_ill;
                    end
                end
                BUSY: begin
                    // latency is exact; the MDU result is taken on this cycle
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        ov_d    = 1'b1;
                        code_d  = ALU_ADD;
                        msel_d  = 1'b1;
                        ill_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            code_q  <= ALU_ADD;
            msel_q  <= 1'b0;
            ill_q   <= 1'b0;
            start_q <= 1'b0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            code_q  <= code_d;
            msel_q  <= msel_d;
            ill_q   <= ill_d;
            start_q <= start_d;
            op_q    <= op_d;
        end
    end

    assign out_valid  = ov_q;
    assign alucontrol = ALUCTRL_W'(code_q);
    assign mdu_sel    = msel_q;
    assign illegal    = ill_q;
    assign mdu_start  = start_q;
    assign mdu_op     = op_q;
    assign busy       = (state_q == BUSY);

endmodule

// File: tb/tb_alu_decode_mc.sv
// Self-checking bench for alu_decode_mc: decode table, MDU latency,
// backpressure, flush, ENABLE_M=0 and randomized traffic vs a model.
module tb_alu_decode_mc;

    localparam int MUL_L = 8;
    localparam int DIV_L = 33;

    logic       clk = 1'b0;
    logic       reset, flush, in_valid, out_ready;
    logic       op5, f7b5, f7b0;
    logic [2:0] funct3;
    logic [1:0] aluop;

    logic       in_ready, out_valid, mdu_sel, illegal, mdu_start, busy;
    logic [3:0] alucontrol;
    logic [2:0] mdu_op;

    logic       nm_in_ready, nm_out_valid, nm_mdu_sel, nm_illegal;
    logic       nm_mdu_start, nm_busy;
    logic [3:0] nm_alucontrol;
    logic [2:0] nm_mdu_op;

    int vectors = 0;
    int miscompares = 0;
    int nm_starts = 0;

    // behavioural model state
    bit         m_ov, m_msel, m_ill, m_start;
    logic [3:0] m_code;
    logic [2:0] m_op;
    int         m_busy;

    always #5 clk = ~clk;

    alu_decode_mc #(
        .ALUCTRL_W (4), .ENABLE_M (1'b1), .MUL_LAT (MUL_L), .DIV_LAT (DIV_L)
    ) dut (
        .clk (clk), .reset (reset), .flush (flush),
        .in_valid (in_valid), .in_ready (in_ready),
        .op5 (op5), .f7b5 (f7b5), .f7b0 (f7b0),
        .funct3 (funct3), .aluop (aluop),
        .out_valid (out_valid), .out_ready (out_ready),
        .alucontrol (alucontrol), .mdu_sel (mdu_sel), .illegal (illegal),
        .mdu_start (mdu_start), .mdu_op (mdu_op), .busy (busy)
    );

    alu_decode_mc #(
        .ALUCTRL_W (4), .ENABLE_M (1'b0), .MUL_LAT (2), .DIV_LAT (33)
    ) dut_nm (
        .clk (clk), .reset (reset), .flush (flush),
        .in_valid (in_valid), .in_ready (nm_in_ready),
        .op5 (op5), .f7b5 (f7b5), .f7b0 (f7b0),
        .funct3 (funct3), .aluop (aluop),
        .out_valid (nm_out_valid), .out_ready (out_ready),
        .alucontrol (nm_alucontrol), .mdu_sel (nm_mdu_sel),
        .illegal (nm_illegal), .mdu_start (nm_mdu_start),
        .mdu_op (nm_mdu_op), .busy (nm_busy)
    );

    always @(posedge clk) if (nm_mdu_start === 1'b1) nm_starts++;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode written straight from the opcode rules.
    task automatic ref_dec(input logic [1:0] a, input logic o5, b5, b0,
                           input logic [2:0] f, input bit en,
                           output logic [3:0] code, output bit ism,
                           output bit ill);
        code = 4'h2;
        ism  = 0;
        ill  = 0;
        if (a == 2'b00) code = 4'h2;
        else if (a == 2'b01) code = 4'h6;
        else if (a == 2'b11) code = 4'h3;
        else if (o5 && b0) begin
            ism = en;
            ill = !en;
        end else if (o5 && b5 && f != 0 && f != 5) ill = 1;
        else begin
            case (f)
                0: code = (o5 && b5) ? 4'h6 : 4'h2;
                1: code = 4'h8;
                2: code = 4'h7;
                3: code = 4'h5;
                4: code = 4'h4;
                5: code = b5 ? 4'hA : 4'h9;
                6: code = 4'h1;
                default: code = 4'h0;
            endcase
        end
    endtask

    // One clock: check in_ready, advance model on the edge, check outputs.
    task automatic cycle();
        bit ready_exp, acc, fire, ism, ill;
        logic [3:0] c;
        #1;
        ready_exp = (m_busy == 0) && (!m_ov || out_ready) && !flush;
        if (!reset) chk("in_ready", in_ready, ready_exp);
        acc  = !reset && in_valid && ready_exp;
        fire = m_ov && out_ready;
        ref_dec(aluop, op5, f7b5, f7b0, funct3, 1'b1, c, ism, ill);
        @(posedge clk);
        if (reset) begin
            m_ov = 0; m_code = 4'h2; m_msel = 0; m_ill = 0;
            m_busy = 0; m_start = 0; m_op = 0;
        end else if (flush) begin
            m_ov = 0; m_busy = 0; m_start = 0;
        end else begin
            m_start = 0;
            if (fire) m_ov = 0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_ov = 1; m_code = 4'h2; m_msel = 1; m_ill = 0;
                end
            end else if (acc && ism) begin
                m_busy  = funct3[2] ? DIV_L : MUL_L;
                m_start = 1;
                m_op    = funct3;
            end else if (acc) begin
                m_ov = 1; m_code = c; m_msel = 0; m_ill = ill;
            end
        end
        #1;
        chk("out_valid", out_valid, m_ov);
        chk("busy", busy, m_busy > 0);
        chk("mdu_start", mdu_start, m_start);
        if (m_start) chk("mdu_op", mdu_op, m_op);
        if (m_ov) begin
            chk("alucontrol", alucontrol, m_code);
            chk("mdu_sel", mdu_sel, m_msel);
            chk("illegal", illegal, m_ill);
        end
    endtask

    task automatic set_op(input logic [1:0] a, input logic o5, b5, b0,
                          input logic [2:0] f);
        aluop = a; op5 = o5; f7b5 = b5; f7b0 = b0; funct3 = f;
    endtask

    typedef struct {
        string      name;
        logic [1:0] aluop;
        logic       o5, b5, b0;
        logic [2:0] f3;
        logic [3:0] code;
        logic       ill;
    } vec_t;

    initial begin
        vec_t tbl[$];
        int lat, bc;

        reset = 1; flush = 0; in_valid = 0; out_ready = 0;
        set_op(2'b00, 0, 0, 0, 3'b000);

        tbl.push_back('{"add_aluop00", 2'b00, 1, 1, 0, 3'd7, 4'h2, 0});
        tbl.push_back('{"sub_aluop01", 2'b01, 0, 0, 0, 3'd5, 4'h6, 0});
        tbl.push_back('{"lui_passb",   2'b11, 1, 1, 0, 3'd3, 4'h3, 0});
        tbl.push_back('{"r_sub",       2'b10, 1, 1, 0, 3'd0, 4'h6, 0});
        tbl.push_back('{"r_add",       2'b10, 1, 0, 0, 3'd0, 4'h2, 0});
        tbl.push_back('{"addi",        2'b10, 0, 1, 0, 3'd0, 4'h2, 0});
        tbl.push_back('{"srai",        2'b10, 0, 1, 0, 3'd5, 4'hA, 0});
        tbl.push_back('{"srli",        2'b10, 0, 0, 0, 3'd5, 4'h9, 0});
        tbl.push_back('{"r_sra",       2'b10, 1, 1, 0, 3'd5, 4'hA, 0});
        tbl.push_back('{"sll",         2'b10, 1, 0, 0, 3'd1, 4'h8, 0});
        tbl.push_back('{"slli_b5",     2'b10, 0, 1, 0, 3'd1, 4'h8, 0});
        tbl.push_back('{"slt",         2'b10, 1, 0, 0, 3'd2, 4'h7, 0});
        tbl.push_back('{"sltu",        2'b10, 1, 0, 0, 3'd3, 4'h5, 0});
        tbl.push_back('{"xor",         2'b10, 1, 0, 0, 3'd4, 4'h4, 0});
        tbl.push_back('{"or",          2'b10, 1, 0, 0, 3'd6, 4'h1, 0});
        tbl.push_back('{"and",         2'b10, 1, 0, 0, 3'd7, 4'h0, 0});
        tbl.push_back('{"ill_r_and",   2'b10, 1, 1, 0, 3'd7, 4'h2, 1});
        tbl.push_back('{"ill_r_sll",   2'b10, 1, 1, 0, 3'd1, 4'h2, 1});

        repeat (2) cycle();
        reset = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alucontrol", alucontrol, 4'h2);
        chk("rst_mdu_sel", mdu_sel, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_mdu_start", mdu_start, 0);
        chk("rst_mdu_op", mdu_op, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);

        // decode table, back-to-back at one per cycle
        out_ready = 1;
        in_valid  = 1;
        foreach (tbl[i]) begin
            set_op(tbl[i].aluop, tbl[i].o5, tbl[i].b5, tbl[i].b0, tbl[i].f3);
            cycle();
            chk({tbl[i].name, "_valid"}, out_valid, 1);
            chk({tbl[i].name, "_code"}, alucontrol, tbl[i].code);
            chk({tbl[i].name, "_ill"}, illegal, tbl[i].ill);
        end
        in_valid = 0;
        cycle();

        // divide: start one cycle after accept, result LAT+1 after accept
        set_op(2'b10, 1, 0, 1, 3'd4);
        in_valid = 1;
        cycle();
        chk("div_start", mdu_start, 1);
        chk("div_op", mdu_op, 3'd4);
        set_op(2'b10, 1, 0, 0, 3'd7);
        lat = 1;
        bc  = busy;
        while (!out_valid && lat < 60) begin
            cycle();
            lat++;
            bc += busy;
        end
        in_valid = 0;
        chk("div_latency", lat, DIV_L + 1);
        chk("div_busy_cycles", bc, DIV_L);
        chk("div_mdu_sel", mdu_sel, 1);
        chk("div_code", alucontrol, 4'h2);
        cycle();

        // backpressure: and, or, xor with consumer stalled
        out_ready = 0;
        in_valid  = 1;
        set_op(2'b10, 1, 0, 0, 3'd7);
        cycle();
        set_op(2'b10, 1, 0, 0, 3'd6);
        repeat (3) begin
            cycle();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_code", alucontrol, 4'h0);
            #1;
            chk("bp_no_ready", in_ready, 0);
        end
        out_ready = 1;
        cycle();
        chk("bp_second", alucontrol, 4'h1);
        set_op(2'b10, 1, 0, 0, 3'd4);
        cycle();
        chk("bp_third", alucontrol, 4'h4);
        in_valid = 0;
        cycle();
        chk("bp_drained", out_valid, 0);

        // flush on cycle 5 of a multiply
        set_op(2'b10, 1, 0, 1, 3'd0);
        in_valid = 1;
        cycle();
        in_valid = 0;
        repeat (4) cycle();
        chk("fl_busy_before", busy, 1);
        flush = 1;
        cycle();
        flush = 0;
        chk("fl_busy", busy, 0);
        chk("fl_out_valid", out_valid, 0);
        #1;
        chk("fl_in_ready", in_ready, 1);
        repeat (15) begin
            cycle();
            chk("fl_no_stale", out_valid, 0);
        end

        // ENABLE_M=0 instance sees an M encoding as illegal
        set_op(2'b10, 1, 0, 1, 3'd0);
        in_valid = 1;
        cycle();
        in_valid = 0;
        chk("nm_valid", nm_out_valid, 1);
        chk("nm_illegal", nm_illegal, 1);
        chk("nm_code", nm_alucontrol, 4'h2);
        chk("nm_mdu_sel", nm_mdu_sel, 0);
        chk("nm_busy", nm_busy, 0);
        repeat (MUL_L + 2) cycle();

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            reset     = ($urandom_range(0, 299) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            set_op(2'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 4) == 0), 3'($urandom));
            cycle();
        end
        reset = 0; flush = 0; in_valid = 0; out_ready = 1;
        repeat (3) cycle();

        chk("nm_never_started", nm_starts, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
